fp_int_convert_unit: RTL and testbench
======================================

// Module: fp_int_convert_unit
// PURPOSE
// - Multi-cycle IEEE-754 single <-> 32-bit two's-complement integer converter (cvt.s.w, trunc.w.s) for the FP coprocessor.
// - Sits beside floating_point_unit on the FP register-file read/write path; the decoder drives it with a valid/ready handshake.
// - Iterative: one normalise/denormalise shift per cycle, then a single round/pack cycle.
// PARAMETERS
// - INVALID_INT   32'h7FFFFFFF   integer result on invalid conversion (NaN, Inf, out of range)
// - QUIET_ZERO    1'b1           1: float->int of +/-0 and |x|<1 returns 32'h0 (never -0 artefacts)
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   synchronous, active-high reset
// - in_valid   in   1   request valid
// - in_ready   out  1   unit can accept (high only in IDLE)
// - op         in   1   0 = cvt.s.w (int->float), 1 = trunc.w.s (float->int, round toward zero)
// - operand    in   32  int or float bits, sampled on accept
// - out_valid  out  1   result valid; held until out_ready
// - out_ready  in   1   consumer takes result
// - result     out  32  converted value
// - invalid    out  1   invalid-operation flag, valid with out_valid
// - inexact    out  1   inexact flag, valid with out_valid
// BEHAVIOUR
// - Reset: state IDLE; in_ready=1; out_valid=0; result=0; invalid=0; inexact=0. Reset mid-conversion aborts; no partial output ever appears.
// - Accept when in_valid & in_ready at edge k; operand and op registered; state->NORM.
// - FSM: IDLE -> NORM -> ROUND -> DONE -> IDLE. in_ready=0 outside IDLE; in_valid ignored while busy.
// - DONE: out_valid=1, result/flags stable until out_ready=1; then IDLE. No accept in the DONE->IDLE cycle (one bubble).
// - int->float (op=0):
//   . sign=operand[31]; mag=|operand| as 32-bit unsigned (0x80000000 -> 2^31).
//   . NORM: if mag==0 or mag[31]==1 go ROUND, else mag<<=1 and shift count s++ (one bit/cycle).
//   . ROUND: exp=158-s; frac=mag[30:8]; guard=mag[7]; sticky=|mag[6:0];
//     round-to-nearest-even: up = guard & (sticky | frac[0]); frac carry-out -> frac=0, exp+1.
//   . inexact=guard|sticky; invalid=0. mag==0 -> result 32'h00000000.
//   . Latency accept->out_valid = s+2 cycles (2 for zero and |x|>=2^31, 33 for 1).
// - float->int (op=1): e=operand[30:23], f=operand[22:0].
//   . e==255 (Inf/NaN) or e>=158: invalid=1, result=INVALID_INT. Exception: operand==32'hCF000000 -> 32'h80000000, invalid=0.
//   . e<127 (incl. zero, denormals): result 0; inexact = (e!=0)|(f!=0); latency 2.
//   . Otherwise mag={1,f,8'b0}; NORM shifts right 158-e times, ORing shifted-out bits into sticky.
//   . ROUND: result = sign ? -mag : mag; inexact=sticky. No rounding increment (truncate).
// - Width rules: shift count 5 bits; exp computed in 9 bits, packed [7:0]; exponent never overflows for 32-bit int inputs.
// - All outputs registered; no combinational path in_valid->out_valid or out_ready->in_ready.
// STRUCTURE
// - Shared include fpu_defs.vh: FP_EXP_BIAS=127, FP_EXP_MAX=255, FP_INT_EXP_LIMIT=158, FP_INT_INVALID=32'h7FFFFFFF,
//   FP_QNAN=32'h7FC00000, CVT op encodings; floating_point_unit reuses the same constants.
// - One sub-module: fp_round_rne (combinational: {exp,frac,guard,sticky} -> packed bits + inexact), used in ROUND.
// - FSM, shift register, sticky and shift counter stay in the top module.
// TESTING
// - op=0, operand=32'h00000001 -> 0x3F800000, inexact=0, out_valid exactly 33 cycles after accept.
// - op=0: 0x7FFFFFFF -> 0x4F000000 inexact=1; 0x01000001 -> 0x4B800000 inexact=1 (tie to even);
//   0x80000000 -> 0xCF000000 inexact=0; 0x00000000 -> 0x00000000 latency 2.
// - op=1: 0xC0700000 (-3.75) -> 0xFFFFFFFD inexact=1; 0x3F000000 (0.5) -> 0 inexact=1; 0x4B000001 -> 0x00800001 inexact=0.
// - op=1 invalid: 0x7F800000, 0x7FC00000, 0x4F000000 -> 0x7FFFFFFF invalid=1; 0xCF000000 -> 0x80000000 invalid=0.
// - Handshake: out_ready=0 for 10 cycles -> result/flags stable, in_ready=0; in_valid pulses while busy not accepted;
//   in_valid and out_ready both high in DONE -> request accepted one cycle later, not the same cycle.
// - rst asserted mid-NORM -> next cycle IDLE, in_ready=1, out_valid=0, result=0; following request converts correctly.

Source files
------------

// File: rtl/fp_int_convert_unit_pkg.sv
// Shared FP constants, op encodings, FSM states and rounder payload for the
// int<->float conversion unit.
package fp_int_convert_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned CNT_W  = 5;

  localparam logic [EXP_W-1:0] FP_EXP_BIAS      = 8'd127;
  localparam logic [EXP_W-1:0] FP_EXP_MAX       = 8'd255;
  localparam logic [EXP_W-1:0] FP_INT_EXP_LIMIT = 8'd158;
  localparam logic [XLEN-1:0]  FP_INT_INVALID   = 32'h7FFF_FFFF;
  localparam logic [XLEN-1:0]  FP_NEG_2P31      = 32'hCF00_0000;
  localparam logic [XLEN-1:0]  INT_MIN          = 32'h8000_0000;

  typedef enum logic {
    CVT_S_W   = 1'b0,
    TRUNC_W_S = 1'b1
  } cvt_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } cvt_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W:0]    exp;
    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
  } rne_in_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and pack of a normalised single-precision value.
module fp_round_rne
  import fp_int_convert_unit_pkg::*;
(
  input  rne_in_t              rne_i,
  output logic [XLEN-1:0]      bits_o,
  output logic                 inexact_o
);

  logic              up;
  logic [FRAC_W:0]   frac_sum;
  logic [EXP_W:0]    exp_rnd;

  always_comb begin
    up        = rne_i.guard & (rne_i.sticky | rne_i.frac[0]);
    frac_sum  = {1'b0, rne_i.frac} + (FRAC_W+1)'(up);
    // Mantissa carry-out leaves frac at zero and bumps the exponent.
    exp_rnd   = rne_i.exp + (EXP_W+1)'(frac_sum[FRAC_W]);
    bits_o    = {rne_i.sign, (XLEN-1)'({exp_rnd, frac_sum[FRAC_W-1:0]})};
    inexact_o = rne_i.guard | rne_i.sticky;
  end

endmodule

// File: rtl/fp_int_convert_unit.sv
// Iterative cvt.s.w / trunc.w.s converter: one shift per cycle in NORM,
// then a single round/pack cycle, result held in DONE until taken.
module fp_int_convert_unit
  import fp_int_convert_unit_pkg::*;
#(
  parameter logic [31:0] INVALID_INT = FP_INT_INVALID,
  parameter bit          QUIET_ZERO  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic [XLEN-1:0] operand,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            invalid,
  output logic            inexact
);

  cvt_state_e        state_q;
  cvt_op_e           op_q;
  logic              sign_q;
  logic [XLEN-1:0]   mag_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sticky_q;
  logic              spec_q;
  logic [XLEN-1:0]   spec_res_q;
  logic              spec_inv_q;
  logic              spec_inx_q;

  logic [EXP_W-1:0]  acc_e;
  logic [FRAC_W-1:0] acc_f;
  logic [XLEN-1:0]   acc_mag;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_spec;
  logic [XLEN-1:0]   acc_res;
  logic              acc_inv;
  logic              acc_inx;

  rne_in_t           rne_in;
  logic [XLEN-1:0]   rne_bits;
  logic              rne_inx;

  // Accept-time decode: magnitude, shift budget and the no-shift special cases.
  always_comb begin
    acc_e    = operand[30:23];
    acc_f    = operand[22:0];
    acc_mag  = {1'b1, acc_f, 8'b0};
    acc_cnt  = '0;
    acc_spec = 1'b0;
    acc_res  = '0;
    acc_inv  = 1'b0;
    acc_inx  = 1'b0;
    if (op == CVT_S_W) begin
      acc_mag = operand[31] ? (-operand) : operand;
    end else if (operand == FP_NEG_2P31) begin
      acc_spec = 1'b1;
      acc_res  = INT_MIN;
    end else if (acc_e == FP_EXP_MAX || acc_e >= FP_INT_EXP_LIMIT) begin
      acc_spec = 1'b1;
      acc_res  = INVALID_INT;
      acc_inv  = 1'b1;
    end else if (acc_e < FP_EXP_BIAS) begin
      acc_spec = 1'b1;
      acc_res  = QUIET_ZERO ? '0 : {operand[31], 31'b0};
      acc_inx  = (acc_e != '0) | (acc_f != '0);
    end else begin
      acc_cnt  = CNT_W'(FP_INT_EXP_LIMIT - acc_e);
    end
  end

  always_comb begin
    rne_in.sign   = sign_q;
    rne_in.exp    = 9'(FP_INT_EXP_LIMIT) - 9'(cnt_q);
    rne_in.frac   = mag_q[30:8];
    rne_in.guard  = mag_q[7];
    rne_in.sticky = |mag_q[6:0];
  end

  fp_round_rne u_round (
    .rne_i     (rne_in),
    .bits_o    (rne_bits),
    .inexact_o (rne_inx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      invalid    <= 1'b0;
      inexact    <= 1'b0;
      op_q       <= CVT_S_W;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_inv_q <= 1'b0;
      spec_inx_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          op_q       <= cvt_op_e'(op);
          sign_q     <= operand[31];
          mag_q      <= acc_mag;
          cnt_q      <= acc_cnt;
          sticky_q   <= 1'b0;
          spec_q     <= acc_spec;
          spec_res_q <= acc_res;
          spec_inv_q <= acc_inv;
          spec_inx_q <= acc_inx;
          in_ready   <= 1'b0;
          state_q    <= ST_NORM;
        end
        ST_NORM: begin
          if (op_q == CVT_S_W) begin
            if (mag_q == '0 || mag_q[31]) begin
              state_q <= ST_ROUND;
            end else begin
              mag_q <= mag_q << 1;
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (spec_q || cnt_q == '0) begin
            state_q <= ST_ROUND;
          end else begin
            sticky_q <= sticky_q | mag_q[0];
            mag_q    <= mag_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
          end
        end
        ST_ROUND: begin
          if (op_q == CVT_S_W) begin
            result  <= (mag_q == '0) ? '0 : rne_bits;
            inexact <= (mag_q != '0) & rne_inx;
            invalid <= 1'b0;
          end else if (spec_q) begin
            result  <= spec_res_q;
            inexact <= spec_inx_q;
            invalid <= spec_inv_q;
          end else begin
            result  <= sign_q ? (-mag_q) : mag_q;
            inexact <= sticky_q;
            invalid <= 1'b0;
          end
          out_valid <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int_convert_unit.sv
// Directed-vector bench for fp_int_convert_unit with hand-computed results.
module tb_fp_int_convert_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        invalid;
  logic        inexact;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_int_convert_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic op_v, input logic [31:0] opnd);
    @(negedge clk);
    in_valid = 1'b1;
    op       = op_v;
    operand  = opnd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic        op;
    logic [31:0] opnd;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    vecs.push_back('{"i2f_one",    1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 33});
    vecs.push_back('{"i2f_max",    1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 1'b1, 3});
    vecs.push_back('{"i2f_tie",    1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1, 9});
    vecs.push_back('{"i2f_tieup",  1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b0, 1'b1, 9});
    vecs.push_back('{"i2f_min",    1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{"i2f_zero",   1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{"i2f_m1",     1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33});
    vecs.push_back('{"f2i_m3p75",  1'b1, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 1'b1, 32});
    vecs.push_back('{"f2i_half",   1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2});
    vecs.push_back('{"f2i_exact",  1'b1, 32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 10});
    vecs.push_back('{"f2i_one",    1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 33});
    vecs.push_back('{"f2i_negz",   1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{"f2i_inf",    1'b1, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, -1});
    vecs.push_back('{"f2i_nan",    1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, -1});
    vecs.push_back('{"f2i_2p31",   1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, -1});
    vecs.push_back('{"f2i_m2p31",  1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, -1});

    rst = 1'b1; in_valid = 1'b0; op = 1'b0; operand = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'h0);
    check("rst_flags",     32'({invalid, inexact}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start(vecs[i].op, vecs[i].opnd);
      wait_done(vecs[i].tag, lat);
      check({vecs[i].tag, "_res"}, result, vecs[i].res);
      check({vecs[i].tag, "_inv"}, 32'(invalid), 32'(vecs[i].inv));
      check({vecs[i].tag, "_inx"}, 32'(inexact), 32'(vecs[i].inx));
      if (vecs[i].lat >= 0) check({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      take_out();
      check({vecs[i].tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
    end

    // Output stall with ignored in_valid pulses in DONE.
    start(1'b1, 32'hC070_0000);
    wait_done("stall", lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      op       = 1'b0;
      operand  = 32'h0000_0001;
      @(posedge clk);
      #1;
      check("stall_res",   result, 32'hFFFF_FFFD);
      check("stall_flags", 32'({out_valid, in_ready, invalid, inexact}), 32'b1001);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_out();
    repeat (3) @(posedge clk);
    #1;
    check("stall_no_accept", 32'({in_ready, out_valid}), 32'b10);

    // in_valid pulse during NORM is dropped.
    start(1'b0, 32'h0000_0001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; op = 1'b1; operand = 32'h4B00_0001;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    wait_done("busy", lat);
    check("busy_res", result, 32'h3F80_0000);
    take_out();
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_second", 32'({in_ready, out_valid}), 32'b10);

    // in_valid + out_ready together in DONE: one bubble before accept.
    start(1'b0, 32'h8000_0000);
    wait_done("b2b_first", lat);
    @(negedge clk);
    in_valid = 1'b1; op = 1'b0; operand = 32'h7FFF_FFFF; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_bubble", 32'({in_ready, out_valid}), 32'b10);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_accept", 32'(in_ready), 32'd0);
    wait_done("b2b_second", lat);
    check("b2b_res", result, 32'h4F00_0000);
    check("b2b_lat", 32'(lat), 32'd3);
    take_out();

    // Reset mid-NORM aborts, then a fresh request converts.
    start(1'b0, 32'h0000_0001);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_state", 32'({in_ready, out_valid}), 32'b10);
    check("mid_rst_res",   result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    start(1'b1, 32'hC070_0000);
    wait_done("post_rst", lat);
    check("post_rst_res", result, 32'hFFFF_FFFD);
    check("post_rst_lat", 32'(lat), 32'd32);
    take_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
